// File: rtl/addertree_23_6_ppa_brent_kung.sv
// Six-operand unsigned adder: 3-level carry-save tree of full adders feeding a Brent-Kung prefix adder.
// Define ADDERTREE_OUT_REG_EN to register S (1-cycle latency, async active-high reset); default is combinational.
module addertree_23_6_ppa_brent_kung #(
    parameter int width = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [width:1]     A1,
    input  logic [width:1]     A2,
    input  logic [width:1]     A3,
    input  logic [width:1]     A4,
    input  logic [width:1]     A5,
    input  logic [width:1]     A6,
    output logic [width+3:1]   S
);

    localparam int W3  = width + 3;
    localparam int LVL = $clog2(W3);

    function automatic logic [W3-1:0] xor3(input logic [W3-1:0] a, b, c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [W3-1:0] maj3(input logic [W3-1:0] a, b, c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [W3-1:0] op1, op2, op3, op4, op5, op6;
    logic [W3-1:0] s1, c1, s2, c2, s3, c3, s4, c4;
    logic [W3-1:0] c1_sh, c2_sh, c3_sh;
    logic [W3-1:0] x_vec, y_vec;
    logic [W3-1:0] p_bit, carry;
    logic [W3-1:0] s_d;

    assign op1 = {3'b000, A1};
    assign op2 = {3'b000, A2};
    assign op3 = {3'b000, A3};
    assign op4 = {3'b000, A4};
    assign op5 = {3'b000, A5};
    assign op6 = {3'b000, A6};

    // Carry-save reduction 6 -> 4 -> 3 -> 2; carries move up one weight at each level.
    assign s1    = xor3(op1, op2, op3);
    assign c1    = maj3(op1, op2, op3);
    assign s2    = xor3(op4, op5, op6);
    assign c2    = maj3(op4, op5, op6);
    assign c1_sh = {c1[W3-2:0], 1'b0};
    assign c2_sh = {c2[W3-2:0], 1'b0};
    assign s3    = xor3(s1, c1_sh, s2);
    assign c3    = maj3(s1, c1_sh, s2);
    assign c3_sh = {c3[W3-2:0], 1'b0};
    assign s4    = xor3(s3, c3_sh, c2_sh);
    assign c4    = maj3(s3, c3_sh, c2_sh);
    assign x_vec = s4;
    assign y_vec = {c4[W3-2:0], 1'b0};

    assign p_bit = x_vec ^ y_vec;

    always_comb begin : bk_prefix
        logic [W3-1:0] gv;
        logic [W3-1:0] pv;
        gv = x_vec & y_vec;
        pv = p_bit;
        // Up-sweep: black cells at positions whose span ends on a 2*stride boundary.
        for (int l = 0; l < LVL; l++) begin
            for (int i = 0; i < W3; i++) begin
                if ((((i + 1) % (2 << l)) == 0) && (i >= (1 << l))) begin
                    gv[i] = gv[i] | (pv[i] & gv[i - (1 << l)]);
                    pv[i] = pv[i] & pv[i - (1 << l)];
                end
            end
        end
        // Down-sweep: grey cells complete the prefixes skipped by the up-sweep.
        for (int l = LVL - 2; l >= 0; l--) begin
            for (int i = 0; i < W3; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    gv[i] = gv[i] | (pv[i] & gv[i - (1 << l)]);
                end
            end
        end
        carry = gv;
    end

    // NOTE: every always_comb output is fully assigned on every path, so no latch can be inferred.
    always_comb begin
        s_d         = '0;
        s_d[0]      = p_bit[0];
        s_d[W3-1:1] = p_bit[W3-1:1] ^ carry[W3-2:0];
    end

`ifdef ADDERTREE_OUT_REG_EN
    logic [W3-1:0] s_q;
    logic          msb_unused;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign S = s_q;
    assign msb_unused = ^{c1[W3-1], c2[W3-1], c3[W3-1], c4[W3-1], carry[W3-1]};
`else
    logic msb_unused;

    assign S = s_d;
    // Top carries are provably zero for legal inputs; clk/rst are idle in this build.
    assign msb_unused = ^{c1[W3-1], c2[W3-1], c3[W3-1], c4[W3-1], carry[W3-1], clk, rst};
`endif

endmodule

// File: tb/tb_addertree_23_6_ppa_brent_kung.sv
// Self-checking bench for addertree_23_6_ppa_brent_kung (width 23 and width 4 instances).
// Handles both builds; define ADDERTREE_OUT_REG_EN for the registered one.
module tb_addertree_23_6_ppa_brent_kung;

    logic        clk;
    logic        rst;
    logic [23:1] a1, a2, a3, a4, a5, a6;
    logic [26:1] s23;
    logic [4:1]  b1, b2, b3, b4, b5, b6;
    logic [7:1]  s4;

    int n_cmp;
    int n_err;

    addertree_23_6_ppa_brent_kung #(.width(23)) dut23 (
        .clk(clk), .rst(rst),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4), .A5(a5), .A6(a6),
        .S(s23)
    );

    addertree_23_6_ppa_brent_kung #(.width(4)) dut4 (
        .clk(clk), .rst(rst),
        .A1(b1), .A2(b2), .A3(b3), .A4(b4), .A5(b5), .A6(b6),
        .S(s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, truncated to the output width.
    function automatic logic [25:0] model23(input logic [23:1] x1, x2, x3, x4, x5, x6);
        longint sum;
        sum = longint'(x1) + longint'(x2) + longint'(x3) + longint'(x4) + longint'(x5) + longint'(x6);
        return sum[25:0];
    endfunction

    function automatic logic [6:0] model4(input logic [4:1] x1, x2, x3, x4, x5, x6);
        int sum;
        sum = int'(x1) + int'(x2) + int'(x3) + int'(x4) + int'(x5) + int'(x6);
        return sum[6:0];
    endfunction

    task automatic settle();
`ifdef ADDERTREE_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #10;
`endif
    endtask

    task automatic drive23(input logic [23:1] x1, x2, x3, x4, x5, x6);
        a1 = x1; a2 = x2; a3 = x3; a4 = x4; a5 = x5; a6 = x6;
    endtask

    task automatic drive4(input logic [4:1] x1, x2, x3, x4, x5, x6);
        b1 = x1; b2 = x2; b3 = x3; b4 = x4; b5 = x5; b6 = x6;
    endtask

    task automatic test_reset();
        logic [25:0] exp;
        drive23(23'($urandom), 23'($urandom), 23'($urandom), 23'($urandom), 23'($urandom), 23'($urandom));
        drive4(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
`ifdef ADDERTREE_OUT_REG_EN
        #1;
        n_cmp++;
        if (s23 !== 26'd0) begin
            n_err++;
            $display("FAIL reset_s23: got %h expected %h", s23, 26'd0);
        end
        n_cmp++;
        if (s4 !== 7'd0) begin
            n_err++;
            $display("FAIL reset_s4: got %h expected %h", s4, 7'd0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (s23 !== 26'd0) begin
            n_err++;
            $display("FAIL reset_held_over_edge: got %h expected %h", s23, 26'd0);
        end
        rst = 1'b0;
        settle();
        exp = model23(a1, a2, a3, a4, a5, a6);
        n_cmp++;
        if (s23 !== exp) begin
            n_err++;
            $display("FAIL first_edge_after_reset: got %h expected %h", s23, exp);
        end
`else
        #10;
        exp = model23(a1, a2, a3, a4, a5, a6);
        n_cmp++;
        if (s23 !== exp) begin
            n_err++;
            $display("FAIL comb_ignores_rst: got %h expected %h", s23, exp);
        end
        n_cmp++;
        if (s4 !== 7'd90) begin
            n_err++;
            $display("FAIL comb_ignores_rst_w4: got %h expected %h", s4, 7'd90);
        end
        rst = 1'b0;
        #10;
`endif
    endtask

    task automatic test_zero();
        drive23(23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0);
        drive4(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        settle();
        n_cmp++;
        if (s23 !== 26'd0) begin
            n_err++;
            $display("FAIL all_zero: got %h expected %h", s23, 26'd0);
        end
        n_cmp++;
        if (s4 !== 7'd0) begin
            n_err++;
            $display("FAIL all_zero_w4: got %h expected %h", s4, 7'd0);
        end
    endtask

    task automatic test_all_ones();
        logic [25:0] exp;
        drive23(23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF);
        settle();
        exp = model23(a1, a2, a3, a4, a5, a6);
        n_cmp++;
        if (s23 !== exp || s23 !== 26'h2FFFFFA) begin
            n_err++;
            $display("FAIL all_ones: got %h expected %h", s23, 26'h2FFFFFA);
        end
    endtask

    task automatic test_carry_ripple();
        drive23(23'h7FFFFF, 23'h000001, 23'd0, 23'd0, 23'd0, 23'd0);
        settle();
        n_cmp++;
        if (s23 !== 26'h0800000) begin
            n_err++;
            $display("FAIL ripple_full_width: got %h expected %h", s23, 26'h0800000);
        end
        drive23(23'h400000, 23'h400000, 23'h400000, 23'h400000, 23'h400000, 23'h400000);
        settle();
        n_cmp++;
        if (s23 !== 26'h1800000) begin
            n_err++;
            $display("FAIL ripple_msb_stack: got %h expected %h", s23, 26'h1800000);
        end
    endtask

    task automatic test_random();
        logic [25:0] exp23;
        logic [6:0]  exp4;
        for (int k = 0; k < 60; k++) begin
            drive23(23'($urandom), 23'($urandom), 23'($urandom), 23'($urandom), 23'($urandom), 23'($urandom));
            drive4(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            exp23 = model23(a1, a2, a3, a4, a5, a6);
            exp4  = model4(b1, b2, b3, b4, b5, b6);
            settle();
            n_cmp++;
            if (s23 !== exp23) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", k, s23, exp23);
            end
            n_cmp++;
            if (s4 !== exp4) begin
                n_err++;
                $display("FAIL random_w4[%0d]: got %h expected %h", k, s4, exp4);
            end
        end
    endtask

    task automatic test_async_reset();
        drive23(23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF);
        settle();
        n_cmp++;
        if (s23 !== 26'h2FFFFFA) begin
            n_err++;
            $display("FAIL pre_reset_load: got %h expected %h", s23, 26'h2FFFFFA);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
`ifdef ADDERTREE_OUT_REG_EN
        if (s23 !== 26'd0) begin
            n_err++;
            $display("FAIL async_reset_clear: got %h expected %h", s23, 26'd0);
        end
`else
        if (s23 !== 26'h2FFFFFA) begin
            n_err++;
            $display("FAIL comb_rst_no_effect: got %h expected %h", s23, 26'h2FFFFFA);
        end
`endif
        #1;
        rst = 1'b0;
        settle();
        n_cmp++;
        if (s23 !== 26'h2FFFFFA) begin
            n_err++;
            $display("FAIL reload_after_reset: got %h expected %h", s23, 26'h2FFFFFA);
        end
    endtask

    task automatic test_width4();
        drive4(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        settle();
        n_cmp++;
        if (s4 !== 7'h5A) begin
            n_err++;
            $display("FAIL width4_all_ones: got %h expected %h", s4, 7'h5A);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive23(23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0);
        drive4(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_zero();
        test_all_ones();
        test_carry_ripple();
        test_random();
        test_async_reset();
        test_width4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
